// File: rtl/kyber_pkg.sv
// Shared Kyber constants and types for the CBD sampler.
//   KYBER_N        : coefficients per polynomial
//   eta_e          : centred-binomial parameter select (ETA2 / ETA3)
//   BYTES_ETA2/3   : PRF bytes consumed per job (64*eta)
//   cbd_state_t    : controller FSM state encoding
package kyber_pkg;
    localparam int KYBER_N    = 256;
    localparam int BYTES_ETA2 = 128;
    localparam int BYTES_ETA3 = 192;

    typedef enum logic {ETA2 = 1'b0, ETA3 = 1'b1} eta_e;

    typedef logic [1:0] cbd_state_t;
    localparam cbd_state_t ST_IDLE = 2'd0;
    localparam cbd_state_t ST_RUN  = 2'd1;
    localparam cbd_state_t ST_DONE = 2'd2;

    function automatic logic [7:0] bytes_per_job(eta_e eta);
        return (eta == ETA3) ? 8'(BYTES_ETA3) : 8'(BYTES_ETA2);
    endfunction

    // Stream bits consumed per coefficient (2*eta).
    function automatic logic [4:0] bits_per_coeff(eta_e eta);
        return (eta == ETA3) ? 5'd6 : 5'd4;
    endfunction
endpackage

// File: rtl/cbd_stream_ctrl_if.sv
// Byte-in / coefficient-out stream bundle of the CBD sampler.
//   in_valid/in_ready/in_byte        : PRF byte stream into the sampler
//   out_valid/out_ready/out_coeff/out_index : coefficient stream out
// master = environment side, slave = sampler side.
interface cbd_stream_ctrl_if;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_byte;
    logic              out_valid;
    logic              out_ready;
    logic signed [2:0] out_coeff;
    logic [7:0]        out_index;

    modport master (
        output in_valid, in_byte, out_ready,
        input  in_ready, out_valid, out_coeff, out_index
    );
    modport slave (
        input  in_valid, in_byte, out_ready,
        output in_ready, out_valid, out_coeff, out_index
    );
endinterface

// File: rtl/cbd_coeff.sv
// Combinational CBD sample: popcount of the low eta bits minus popcount of
// the next eta bits.
//   bits  : lowest 6 bits of the stream buffer (bit 0 oldest)
//   eta   : ETA2 uses bits[3:0], ETA3 uses bits[5:0]
//   coeff : signed result in -eta..+eta
module cbd_coeff
    import kyber_pkg::*;
(
    input  logic [5:0]        bits,
    input  eta_e              eta,
    output logic signed [2:0] coeff
);
    logic [2:0] pa, pb;

    always_comb begin
        pa = 3'd0;
        pb = 3'd0;
        if (eta == ETA3) begin
            pa = {2'b0, bits[0]} + {2'b0, bits[1]} + {2'b0, bits[2]};
            pb = {2'b0, bits[3]} + {2'b0, bits[4]} + {2'b0, bits[5]};
        end else begin
            pa = {2'b0, bits[0]} + {2'b0, bits[1]};
            pb = {2'b0, bits[2]} + {2'b0, bits[3]};
        end
        // Both operands are <= 3, so the 3-bit wrap is the exact signed difference.
        coeff = signed'(pa - pb);
    end
endmodule

// File: rtl/cbd_stream_ctrl.sv
// CBD stream controller: turns a PRF byte stream into N_COEFF centred
// binomial samples per job.
//   clk, reset (async, active low)
//   start   : job request, honoured only in IDLE
//   eta_sel : 0 -> eta=2, 1 -> eta=3, latched at start
//   abort   : cancels a running job, no done pulse
//   s       : byte/coefficient stream bundle (slave side)
//   busy    : job running
//   done    : one-cycle pulse after the last coefficient handshake
module cbd_stream_ctrl
    import kyber_pkg::*;
#(
    parameter int N_COEFF = KYBER_N
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               eta_sel,
    input  logic               abort,
    cbd_stream_ctrl_if.slave   s,
    output logic               busy,
    output logic               done
);
    cbd_state_t  state;
    eta_e        eta_q;
    logic [15:0] bitbuf;
    logic [4:0]  fill;
    logic [7:0]  byte_cnt;
    logic [7:0]  idx;

    logic        run, in_fire, out_fire, last;
    logic [4:0]  need, fill_sh, fill_nxt;
    logic [15:0] buf_sh, buf_nxt;

    cbd_coeff u_coeff (
        .bits  (bitbuf[5:0]),
        .eta   (eta_q),
        .coeff (s.out_coeff)
    );

    always_comb begin
        run         = (state == ST_RUN);
        need        = bits_per_coeff(eta_q);
        // fill<=8 guarantees an incoming byte fits in the 16-bit buffer.
        s.in_ready  = run && (fill <= 5'd8) && (byte_cnt < bytes_per_job(eta_q));
        s.out_valid = run && (fill >= need);
        s.out_index = idx;
        in_fire     = s.in_valid && s.in_ready;
        out_fire    = s.out_valid && s.out_ready;
        last        = (idx == 8'(N_COEFF - 1));

        // Consume first, then append the new byte right above what remains.
        fill_sh  = out_fire ? (fill - need) : fill;
        buf_sh   = out_fire ? (bitbuf >> need) : bitbuf;
        buf_nxt  = in_fire ? (buf_sh | ({8'd0, s.in_byte} << fill_sh)) : buf_sh;
        fill_nxt = in_fire ? (fill_sh + 5'd8) : fill_sh;

        busy = run;
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            eta_q    <= ETA2;
            bitbuf   <= '0;
            fill     <= '0;
            byte_cnt <= '0;
            idx      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_RUN;
                        eta_q    <= eta_e'(eta_sel);
                        bitbuf   <= '0;
                        fill     <= '0;
                        byte_cnt <= '0;
                        idx      <= '0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state    <= ST_IDLE;
                        bitbuf   <= '0;
                        fill     <= '0;
                        byte_cnt <= '0;
                        idx      <= '0;
                    end else begin
                        bitbuf <= buf_nxt;
                        fill   <= fill_nxt;
                        if (in_fire)
                            byte_cnt <= byte_cnt + 8'd1;
                        if (out_fire) begin
                            idx <= idx + 8'd1;
                            if (last)
                                state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cbd_stream_ctrl.sv
module tb_cbd_stream_ctrl;
    import kyber_pkg::*;

    logic clk = 1'b0;
    logic reset, start, eta_sel, abort;
    logic busy, done;

    cbd_stream_ctrl_if sif();

    cbd_stream_ctrl #(.N_COEFF(256)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .eta_sel (eta_sel),
        .abort   (abort),
        .s       (sif),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference model: job state, bit FIFO of accepted stream bits (LSB-first).
    int   m_st = 0;          // 0 idle, 1 running, 2 done pulse
    int   m_eta = 2;
    int   m_bytes = 0;
    int   m_idx = 0;
    bit   bq[$];
    int   job_got[$];
    int   done_seen = 0;
    int   cyc = 0;
    int   start_cyc = 0, done_cyc = 0;
    int   first_index = -1;

    // Stimulus source
    int         in_pct = 100, out_pct = 100;
    logic [7:0] src_q[$];
    bit         src_pop = 0;

    bit                holding = 0;
    logic signed [2:0] hold_c;
    logic [7:0]        hold_i;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            m_st = 0;
            bq.delete();
            holding = 0;
        end else begin
            bit exp_rdy, exp_vld, ohs, ihs;
            int a, b;
            exp_rdy = (m_st == 1) && (bq.size() <= 8) && (m_bytes < 64 * m_eta);
            exp_vld = (m_st == 1) && (bq.size() >= 2 * m_eta);
            chk("busy", busy, m_st == 1);
            chk("done", done, m_st == 2);
            chk("in_ready", sif.in_ready, exp_rdy);
            chk("out_valid", sif.out_valid, exp_vld);
            if (holding && sif.out_valid) begin
                chk("hold_coeff", sif.out_coeff, hold_c);
                chk("hold_index", sif.out_index, hold_i);
            end
            ohs = sif.out_valid && sif.out_ready;
            ihs = sif.in_valid && sif.in_ready;
            holding = sif.out_valid && !sif.out_ready;
            hold_c = sif.out_coeff;
            hold_i = sif.out_index;
            if (done) begin
                done_seen++;
                done_cyc = cyc;
            end
            if (ohs) begin
                a = 0;
                b = 0;
                if (bq.size() >= 2 * m_eta) begin
                    for (int i = 0; i < m_eta; i++) a += int'(bq.pop_front());
                    for (int i = 0; i < m_eta; i++) b += int'(bq.pop_front());
                end else begin
                    chk("underflow", bq.size(), 2 * m_eta);
                end
                chk("coeff", sif.out_coeff, a - b);
                chk("index", sif.out_index, m_idx);
                if (job_got.size() == 0) first_index = int'(sif.out_index);
                job_got.push_back(int'(sif.out_coeff));
                m_idx++;
            end
            if (ihs) begin
                for (int i = 0; i < 8; i++) bq.push_back(sif.in_byte[i]);
                m_bytes++;
                src_pop = 1;
            end
            case (m_st)
                0: if (start) begin
                    m_st = 1;
                    m_eta = eta_sel ? 3 : 2;
                    m_bytes = 0;
                    m_idx = 0;
                    bq.delete();
                    job_got.delete();
                    first_index = -1;
                    start_cyc = cyc;
                end
                1: if (abort) begin
                    m_st = 0;
                    bq.delete();
                end else if (ohs && m_idx == 256) begin
                    m_st = 2;
                end
                default: m_st = 0;
            endcase
        end
    end

    always @(posedge clk) begin
        #1;
        if (src_pop) begin
            if (src_q.size() > 0) void'(src_q.pop_front());
            src_pop = 0;
        end
        sif.in_byte   = (src_q.size() > 0) ? src_q[0] : 8'($urandom);
        sif.in_valid  = ($urandom_range(99) < in_pct);
        sif.out_ready = ($urandom_range(99) < out_pct);
    end

    // Starts a job and waits for its done pulse; optionally pokes start
    // (with the other eta) mid-job, which must be ignored.
    task automatic run_job(input bit e3, input int limit, input int poke);
        int d0, t0;
        d0 = done_seen;
        @(posedge clk); #1;
        start = 1'b1;
        eta_sel = e3;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (done_seen == d0 && cyc - t0 < limit) begin
            @(posedge clk); #1;
            start = (poke > 0) && (cyc - t0 == poke);
            eta_sel = start ? !e3 : e3;
        end
        start = 1'b0;
        eta_sel = e3;
        chk("job_timeout", done_seen - d0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_coeffs(input int n, input int limit);
        int k;
        k = 0;
        while (m_idx < n && k < limit) begin
            @(posedge clk);
            k++;
        end
        chk("wait_coeffs_timeout", m_idx >= n, 1);
        #1;
    endtask

    initial begin
        int nz, d0;
        reset = 1'b0; start = 1'b0; eta_sel = 1'b0; abort = 1'b0;
        sif.in_valid = 1'b0; sif.in_byte = 8'h00; sif.out_ready = 1'b0;

        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", sif.in_ready, 0);
        chk("rst_out_valid", sif.out_valid, 0);
        chk("rst_coeff", sif.out_coeff, 0);
        chk("rst_index", sif.out_index, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // eta=2 directed leading bytes
        src_q = '{8'h1B, 8'h03, 8'h0C};
        run_job(1'b0, 3000, 0);
        chk("e2_ncoeff", job_got.size(), 256);
        chk("e2_bytes", m_bytes, 128);
        chk("e2_c0", job_got[0], 1);
        chk("e2_c1", job_got[1], 1);
        chk("e2_c2", job_got[2], 2);
        chk("e2_c3", job_got[3], 0);
        chk("e2_c4", job_got[4], -2);
        chk("e2_c5", job_got[5], 0);

        // eta=3 directed leading bytes
        src_q = '{8'h07, 8'h00, 8'h00, 8'h38, 8'h00, 8'h00};
        run_job(1'b1, 3000, 0);
        chk("e3_ncoeff", job_got.size(), 256);
        chk("e3_bytes", m_bytes, 192);
        chk("e3_c0", job_got[0], 3);
        chk("e3_c1", job_got[1], 0);
        chk("e3_c2", job_got[2], 0);
        chk("e3_c3", job_got[3], 0);
        chk("e3_c4", job_got[4], -3);
        chk("e3_c5", job_got[5], 0);
        chk("e3_c6", job_got[6], 0);
        chk("e3_c7", job_got[7], 0);

        // eta=2 all-ones at full throughput
        src_q.delete();
        for (int i = 0; i < 128; i++) src_q.push_back(8'hFF);
        d0 = done_seen;
        run_job(1'b0, 3000, 0);
        nz = 0;
        foreach (job_got[i]) if (job_got[i] != 0) nz++;
        chk("ff_nonzero", nz, 0);
        chk("ff_ncoeff", job_got.size(), 256);
        chk("ff_bytes", m_bytes, 128);
        chk("ff_done_once", done_seen - d0, 1);
        chk("ff_latency_ok", (done_cyc - start_cyc) <= 258, 1);
        src_q.delete();

        // eta=3 random gaps and backpressure, with an ignored mid-job start
        in_pct = 50;
        out_pct = 50;
        run_job(1'b1, 5000, 37);
        chk("rnd_ncoeff", job_got.size(), 256);
        chk("rnd_bytes", m_bytes, 192);

        // abort after coefficient 100
        d0 = done_seen;
        @(posedge clk); #1;
        start = 1'b1; eta_sel = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_coeffs(101, 5000);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", sif.out_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", done_seen - d0, 0);
        run_job(1'b0, 5000, 0);
        chk("post_abort_first_idx", first_index, 0);
        chk("post_abort_ncoeff", job_got.size(), 256);

        // reset mid-job
        d0 = done_seen;
        @(posedge clk); #1;
        start = 1'b1; eta_sel = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_coeffs(50, 5000);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_in_ready", sif.in_ready, 0);
        chk("mid_rst_out_valid", sif.out_valid, 0);
        chk("mid_rst_coeff", sif.out_coeff, 0);
        chk("mid_rst_index", sif.out_index, 0);
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle", busy, 0);
        chk("post_rst_no_done", done_seen - d0, 0);
        run_job(1'b0, 5000, 0);
        chk("post_rst_first_idx", first_index, 0);
        chk("post_rst_ncoeff", job_got.size(), 256);
        chk("post_rst_bytes", m_bytes, 128);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
